// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its issue controller: opcodes, instruction fields, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_REG_AW = 2;
    localparam int ALU_CNT_W  = 16;

    // Instruction word layout: [15:13] op, [12:11] rd, [10:9] rs1, [8] use_imm, [7:0] imm / [1:0] rs2
    localparam int INSTR_W     = 16;
    localparam int OP_LSB      = 13;
    localparam int OP_W        = 3;
    localparam int RD_LSB      = 11;
    localparam int RS1_LSB     = 9;
    localparam int USE_IMM_BIT = 8;
    localparam int IMM_LSB     = 0;
    localparam int IMM_W       = 8;
    localparam int RS2_LSB     = 0;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SLL = 3'd2,
        OP_LSR = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_EQL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational read ports, one synchronous write port, r0 reads as zero.
// Latency: reads combinational; a write is visible after the next clock edge.
// Backpressure: none; a write is taken whenever we_i is high.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    localparam int NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] regs_q [NREGS];

    // Register storage; writes aimed at r0 are dropped so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue front end for the combinational ALU: decode, operand fetch, ALU drive and result writeback.
// Latency: accept at edge T0, res_valid high in the cycle after edge T1; one instruction per 3 cycles.
// Backpressure: instr_ready is high only in IDLE; words offered at other times are ignored.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW,
    parameter int CNT_W  = ALU_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [REG_AW-1:0] res_rd,
    output logic              busy,
    output logic [CNT_W-1:0]  retired
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_b_q, res_data_q;
    logic [2:0]        alu_op_q;
    logic [REG_AW-1:0] rd_q, res_rd_q;
    logic              res_valid_q;
    logic [CNT_W-1:0]  retired_q;

    logic [REG_AW-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [DATA_W-1:0] rs1_val, rs2_val, imm_val, opnd_b;
    logic [OP_W-1:0]   op_fld;
    logic              use_imm, accept, wb_en;

    // Field decode straight off the offered word; only used on the accepting edge
    assign op_fld   = instr[OP_LSB +: OP_W];
    assign rd_addr  = instr[RD_LSB +: REG_AW];
    assign rs1_addr = instr[RS1_LSB +: REG_AW];
    assign rs2_addr = instr[RS2_LSB +: REG_AW];
    assign use_imm  = instr[USE_IMM_BIT];
    assign imm_val  = DATA_W'(instr[IMM_LSB +: IMM_W]);
    assign opnd_b   = use_imm ? imm_val : rs2_val;

    assign accept = instr_valid && instr_ready;
    assign wb_en  = (state_q == ST_EXEC);

    alu_regfile #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a_i (rs1_addr),
        .raddr_b_i (rs2_addr),
        .rdata_a_o (rs1_val),
        .rdata_b_o (rs2_val),
        .we_i      (wb_en),
        .waddr_i   (rd_q),
        .wdata_i   (alu_result)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs: only IDLE takes a new word
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        busy        = 1'b1;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture on accept, result capture and retire count at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            retired_q   <= '0;
        end else begin
            if (accept) begin
                alu_a_q  <= rs1_val;
                alu_b_q  <= opnd_b;
                alu_op_q <= op_fld;
                rd_q     <= rd_addr;
            end
            res_valid_q <= wb_en;
            if (wb_en) begin
                res_data_q <= alu_result;
                res_rd_q   <= rd_q;
                retired_q  <= retired_q + CNT_W'(1);
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;
    assign retired   = retired_q;

endmodule
